// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes fetch and load/store requests onto one memory port, one transaction outstanding.
// Define MEMARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic        iKill,
  output logic        iValid,
  output logic [31:0] iRdata,
  input  logic        dReq,
  input  logic        dWen,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [2:0]  dSize,
  output logic        dValid,
  output logic [31:0] dRdata,
  output logic        memReq,
  output logic        memWen,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [2:0]  memSize,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, stateNext;
  logic ownerData, drop, dropNext, grantD, grantI, forceFetch, killFetch, arb;
  assign killFetch = iKill && !ownerData;
  assign grantD = dReq && !forceFetch;
  assign grantI = iReq && !grantD;
  assign arb = state == IDLE && (grantD || grantI);
  assign memReq = state == ISSUE;
  assign iRdata = memRdata;
  assign dRdata = memRdata;
  // A kill arriving alongside the response suppresses it before the drop flag can register.
  assign iValid = !rst && state == WAIT && memRvalid && !ownerData && !drop && !iKill;
  assign dValid = !rst && state == WAIT && memRvalid && ownerData;
  always_comb begin
    stateNext = state;
    dropNext = 1'b0;
    if (state == IDLE) begin
      stateNext = arb ? ISSUE : IDLE;
    end else if (state == ISSUE) begin
      stateNext = memGnt ? WAIT : (killFetch ? IDLE : ISSUE);
      dropNext = memGnt && killFetch;
    end else begin
      stateNext = memRvalid ? IDLE : WAIT;
      dropNext = !memRvalid && (drop || killFetch);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ownerData <= 1'b0;
      drop <= 1'b0;
      memWen <= 1'b0;
      memAddr <= '0;
      memWdata <= '0;
      memSize <= '0;
    end else begin
      state <= stateNext;
      drop <= dropNext;
      if (arb) begin
        ownerData <= grantD;
        memWen <= grantD && dWen;
        memAddr <= grantD ? dAddr : iAddr;
        memWdata <= grantD ? dWdata : '0;
        memSize <= grantD ? dSize : 3'b010;
      end else if (stateNext == IDLE) begin
        memWen <= 1'b0;
      end
    end
  end
`ifdef MEMARB_STARVE_GUARD_EN
  logic [3:0] starveCnt;
  assign forceFetch = iReq && starveCnt == 4'(STARVE_LIMIT);
  always_ff @(posedge clk) begin
    if (rst) starveCnt <= '0;
    else if (state == IDLE && (iReq || dReq)) starveCnt <= (grantD && iReq) ? starveCnt + 4'd1 : '0;
  end
`else
  assign forceFetch = 1'b0;
`endif
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one unified memory port between the instruction-fetch port and the load/store port of the pipelined core. Requests are serialized with one transaction outstanding, and responses are routed back to their owner as single-cycle valid pulses. The core stalls a stage while its request is high and its valid is low. The arbiter sits between the core's fetch/data ports and the single-ported memory/bus adapter.

## Interface
- STARVE_LIMIT, 4: consecutive data grants tolerated while fetch waits (used only with the starvation guard compiled in); range 1..15.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- iReq  in  1  fetch request; held with iAddr stable until iValid
- iAddr  in  32  fetch address
- iKill  in  1  fetch redirect; cancels the outstanding fetch
- iValid  out  1  fetch response pulse
- iRdata  out  32  fetch data; combinational copy of memRdata
- dReq  in  1  data request; held with all d* inputs stable until dValid
- dWen  in  1  1 = store
- dAddr  in  32  data address
- dWdata  in  32  store data
- dSize  in  3  funct3-style size code, passed through unchanged
- dValid  out  1  data response pulse (load data or store completion)
- dRdata  out  32  load data; combinational copy of memRdata
- memReq  out  1  memory request, held until memGnt
- memWen  out  1  memory write enable
- memAddr  out  32  memory address
- memWdata  out  32  memory write data
- memSize  out  3  memory size code
- memGnt  in  1  memory accepted the request this cycle
- memRvalid  in  1  response or write ack; earliest the cycle after memGnt
- memRdata  in  32  memory read data

## Operation
- States: IDLE, ISSUE, WAIT. Owner register: FETCH or DATA. Drop flag: 1 bit.
- IDLE: arbitrate. Default rule is dReq over iReq, because the data access belongs to an older instruction. On the edge, the winner's addr/wdata/wen/size are captured into output registers and the state goes to ISSUE. Fetch always captures wen=0 and size=3'b010. With no request, stay in IDLE.
- ISSUE: memReq=1 and the registered fields are driven. memGnt moves the state to WAIT.
- WAIT: memRvalid raises the owner's valid for that cycle only, unless the drop flag is set. The state then returns to IDLE, the drop flag clears, and memReq stays 0.
- iKill with owner FETCH:
  - In ISSUE without memGnt: the request is withdrawn and the state returns to IDLE.
  - In ISSUE with memGnt in the same cycle: the grant wins, the state goes to WAIT, and the drop flag is set.
  - In WAIT: the drop flag is set. If memRvalid arrives in the same cycle, iValid is suppressed.
- iKill with no fetch outstanding, or with owner DATA: no effect.
- A stored iKill never blocks a new fetch arbitration in IDLE.
- A requester that deasserts its req before its valid pulse is a protocol violation. Behaviour in that case is undefined, except for an iKill-accompanied deassert.

## Timing
- Reset: state IDLE, drop 0, starvation counter 0, memReq/memWen 0, memAddr/memWdata 0, memSize 0, iValid/dValid 0.
- Minimum latency: req seen in IDLE at cycle 0 → memReq in cycle 1 (memGnt same cycle) → memRvalid in cycle 2 → valid pulse in cycle 2. Three cycles per access.
- memReq and memWen are driven only from registers. Only the valid/rdata outputs have combinational paths from memory.
- The earliest next arbitration is the cycle after the valid pulse (IDLE). There is no back-to-back issue.
- Reset mid-transaction: the arbiter returns to IDLE immediately and no valid is produced. Any late memRvalid arriving in IDLE is ignored.

## Configuration
- MEMARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each data grant made while iReq=1.
  - When the counter equals STARVE_LIMIT and iReq=1, the next arbitration grants fetch even if dReq=1.
  - The counter clears on any fetch grant, or at an arbitration where iReq=0.
- MEMARB_STARVE_GUARD_EN undefined: strict data priority and no counter logic.

## Test plan
- Fetch only: iReq, iAddr=0x100. memGnt in cycle 1, memRvalid with memRdata=0x00500093 in cycle 2 → iValid=1 with iRdata=0x00500093 in cycle 2, memAddr=0x100, memWen=0.
- Simultaneous: dReq store (dAddr=0x2000, dWdata=0xDEADBEEF, dSize=2) and iReq at 0x104 → memory sees the store first, dValid pulses, then the fetch of 0x104 issues.
- Memory backpressure: memGnt held low for 5 cycles → memReq stays 1 with constant memAddr; no valid until memRvalid.
- Kill in WAIT: fetch of 0x200 granted, iKill=1 in the next cycle, memRvalid 2 cycles later → no iValid. A new fetch of 0x300 issues from IDLE and returns normally.
- Starvation (macro on, STARVE_LIMIT=4): dReq held continuously with back-to-back transactions, iReq=1 → four data grants, then one fetch grant, then data resumes.
- Reset in WAIT followed by a stray memRvalid → all outputs are 0 and no valid pulse appears.
